// File: rtl/wsg_voice_mixer.sv
// wsg_voice_mixer: multi-voice wavetable sound generator.
// CPU-written per-voice frequency/volume/waveform registers. On every sample
// tick an FSM walks the voices (accumulate phase, fetch ROM sample, scale by
// volume, add), then publishes one saturated mixed sample.
// Optional build macro WSG_LEGACY_MAP_EN selects the original arcade register
// map (requires NUM_VOICES == 3); by default a linear 8-byte-per-voice map
// starting at BASE_ADDR is decoded.
module wsg_voice_mixer #(
    parameter int          NUM_VOICES = 3,
    parameter int          ACC_W      = 20,
    parameter int          OUT_W      = 10,
    parameter logic [15:0] BASE_ADDR  = 16'h5040
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [15:0]      ram_addr,
    input  logic [7:0]       cpu_data,
    input  logic             sample_tick,
    output logic [7:0]       rom_addr,
    input  logic [3:0]       rom_data,
    output logic [OUT_W-1:0] sample_out,
    output logic             sample_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int VC_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int SUM_W = 8 + $clog2(NUM_VOICES) + 1;
    localparam int NIB_N = ACC_W / 4;
    localparam int CMP_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;
    localparam logic [VC_W-1:0] LAST_VC = VC_W'(NUM_VOICES - 1);

    typedef enum logic [2:0] {IDLE, ACC, ROM, MAC, DONE} state_t;

    state_t state, state_nx;

    logic [ACC_W-1:0] freq [NUM_VOICES];
    logic [3:0]       vol  [NUM_VOICES];
    logic [2:0]       wave [NUM_VOICES];
    logic [ACC_W-1:0] acc  [NUM_VOICES];

    logic [VC_W-1:0]  vc;
    logic [SUM_W-1:0] sum;
    logic [ACC_W-1:0] acc_nx;
    logic [7:0]       prod;

    logic [NUM_VOICES-1:0] sel_freq, sel_vol, sel_wave;
    logic [2:0]            sel_nib;

    // Only the low nibble of CPU data is ever stored.
    logic unused_cpu_bits;
    assign unused_cpu_bits = ^cpu_data[7:4];

    // Clamp the wide mix sum to the largest representable output code.
    function automatic logic [OUT_W-1:0] sat_out(input logic [SUM_W-1:0] s);
        logic [CMP_W-1:0] wide;
        wide = CMP_W'(s);
        if (wide > CMP_W'({OUT_W{1'b1}}))
            return '1;
        else
            return wide[OUT_W-1:0];
    endfunction

`ifdef WSG_LEGACY_MAP_EN
    if (NUM_VOICES != 3) begin : g_legacy_voice_check
        $error("wsg_voice_mixer: legacy register map requires NUM_VOICES == 3");
    end

    // Arcade map: fixed addresses; voices 1/2 have no writable freq nibble 0.
    always_comb begin
        sel_freq = '0;
        sel_vol  = '0;
        sel_wave = '0;
        sel_nib  = '0;
        if (wr_en) begin
            case (ram_addr)
                16'h5045: sel_wave[0] = 1'b1;
                16'h504A: sel_wave[1] = 1'b1;
                16'h504F: sel_wave[2] = 1'b1;
                16'h5055: sel_vol[0]  = 1'b1;
                16'h505A: sel_vol[1]  = 1'b1;
                16'h505F: sel_vol[2]  = 1'b1;
                16'h5050, 16'h5051, 16'h5052, 16'h5053, 16'h5054: begin
                    sel_freq[0] = 1'b1;
                    sel_nib     = ram_addr[2:0];
                end
                16'h5056, 16'h5057, 16'h5058, 16'h5059: begin
                    sel_freq[1] = 1'b1;
                    sel_nib     = 3'(ram_addr[3:0] - 4'd5);
                end
                16'h505B, 16'h505C, 16'h505D, 16'h505E: begin
                    sel_freq[2] = 1'b1;
                    sel_nib     = 3'(ram_addr[3:0] - 4'd10);
                end
                default: ;
            endcase
        end
    end
`else
    logic [15:0] rel;
    assign rel = ram_addr - BASE_ADDR;

    // Linear map: voice = (addr-BASE)/8, register = (addr-BASE)%8.
    always_comb begin
        sel_freq = '0;
        sel_vol  = '0;
        sel_wave = '0;
        sel_nib  = '0;
        if (wr_en && (ram_addr >= BASE_ADDR)) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (rel[15:3] == 13'(v)) begin
                    if (rel[2:0] == 3'd5)
                        sel_vol[v] = 1'b1;
                    else if (rel[2:0] == 3'd6)
                        sel_wave[v] = 1'b1;
                    else if (int'(rel[2:0]) < NIB_N) begin
                        sel_freq[v] = 1'b1;
                        sel_nib     = rel[2:0];
                    end
                end
            end
        end
    end
`endif

    // CPU register file; writes land on the next edge regardless of FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                freq[v] <= '0;
                vol[v]  <= '0;
                wave[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (sel_freq[v]) begin
                    for (int n = 0; n < NIB_N; n++)
                        if (int'(sel_nib) == n)
                            freq[v][4*n +: 4] <= cpu_data[3:0];
                end
                if (sel_vol[v])
                    vol[v] <= cpu_data[3:0];
                if (sel_wave[v])
                    wave[v] <= cpu_data[2:0];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // FSM next state: three cycles per voice, then one publish cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sample_tick) state_nx = ACC;
            ACC:     state_nx = ROM;
            ROM:     state_nx = MAC;
            MAC:     state_nx = (vc == LAST_VC) ? DONE : ACC;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy   = (state != IDLE);
    assign acc_nx = acc[vc] + freq[vc];
    assign prod   = {4'b0, rom_data} * {4'b0, vol[vc]};

    // Voice datapath: phase accumulate, ROM address, multiply-accumulate, publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VOICES; v++)
                acc[v] <= '0;
            vc           <= '0;
            sum          <= '0;
            sample_out   <= '0;
            rom_addr     <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            overrun      <= sample_tick && (state != IDLE);
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        sum <= '0;
                        vc  <= '0;
                    end
                end
                ACC: begin
                    acc[vc]  <= acc_nx;
                    rom_addr <= {wave[vc], acc_nx[ACC_W-1 -: 5]};
                end
                MAC: begin
                    sum <= sum + SUM_W'(prod);
                    if (vc != LAST_VC)
                        vc <= vc + VC_W'(1);
                end
                DONE: begin
                    sample_out   <= sat_out(sum);
                    sample_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wsg_voice_mixer.sv
// Directed self-checking bench for wsg_voice_mixer (default register map).
// A second instance with OUT_W=9 shares all inputs to observe saturation.
module tb_wsg_voice_mixer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [15:0] ram_addr;
    logic [7:0]  cpu_data;
    logic        sample_tick;
    logic [7:0]  rom_addr;
    logic [3:0]  rom_data;
    logic [9:0]  sample_out;
    logic        sample_valid;
    logic        busy;
    logic        overrun;

    logic [7:0]  rom_addr_s;
    logic [8:0]  sample_out_s;
    logic        sample_valid_s;
    logic        busy_s;
    logic        overrun_s;

    logic [3:0]  rom_mem [256];

    int n_cmp = 0;
    int n_bad = 0;

    int         lat, nvld, novr;
    logic [7:0] a0, a1, a2;
    logic       bmid, bend;

    wsg_voice_mixer #(.NUM_VOICES(3), .ACC_W(20), .OUT_W(10), .BASE_ADDR(16'h5040)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .ram_addr(ram_addr), .cpu_data(cpu_data),
        .sample_tick(sample_tick), .rom_addr(rom_addr), .rom_data(rom_data),
        .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
    );

    wsg_voice_mixer #(.NUM_VOICES(3), .ACC_W(20), .OUT_W(9), .BASE_ADDR(16'h5040)) u_sat (
        .clk(clk), .rst(rst), .wr_en(wr_en), .ram_addr(ram_addr), .cpu_data(cpu_data),
        .sample_tick(sample_tick), .rom_addr(rom_addr_s), .rom_data(rom_data),
        .sample_out(sample_out_s), .sample_valid(sample_valid_s), .busy(busy_s), .overrun(overrun_s)
    );

    always #5 clk = ~clk;

    // Sample ROM with one cycle of read latency.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rom_fill(input logic [3:0] val);
        for (int a = 0; a < 256; a++) rom_mem[a] = val;
    endtask

    // ROM word = waveform number + 1, so each voice's fetch is distinguishable.
    task automatic rom_by_wave();
        logic [7:0] av;
        for (int a = 0; a < 256; a++) begin
            av = 8'(a);
            rom_mem[a] = {1'b0, av[7:5]} + 4'd1;
        end
    endtask

    // Caller is positioned 1 ns after a rising edge.
    task automatic cpu_wr(input logic [15:0] addr, input logic [7:0] data);
        ram_addr = addr;
        cpu_data = data;
        wr_en    = 1'b1;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    // One tick, then observe 14 cycles: latency, per-voice ROM addresses,
    // valid/overrun pulse counts and busy in mid-sequence / at completion.
    task automatic run_tick(output int l, output logic [7:0] r0, output logic [7:0] r1,
                            output logic [7:0] r2, output int nv, output int no,
                            output logic bm, output logic be);
        l = -1; nv = 0; no = 0; r0 = 0; r1 = 0; r2 = 0; bm = 0; be = 1;
        sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) r0 = rom_addr;
            if (c == 4) r1 = rom_addr;
            if (c == 7) r2 = rom_addr;
            if (c == 5) bm = busy;
            if (c == 10) be = busy;
            if (sample_valid) begin
                nv++;
                if (l < 0) l = c;
            end
            if (overrun) no++;
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; ram_addr = '0; cpu_data = '0; sample_tick = 1'b0;
        rom_fill(4'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_sample_out", 32'(sample_out), 0);
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_rom_addr", 32'(rom_addr), 0);

        // All registers zero: latency and zero output
        run_tick(lat, a0, a1, a2, nvld, novr, bmid, bend);
        check("zero_latency", 32'(lat), 10);
        check("zero_nvalid", 32'(nvld), 1);
        check("zero_out", 32'(sample_out), 0);
        check("zero_rom_addr", 32'(a0), 0);
        check("zero_busy_mid", 32'(bmid), 1);
        check("zero_busy_end", 32'(bend), 0);
        check("zero_overrun", 32'(novr), 0);

        // Voice 0: freq 0x08000, vol F, wave 2, ROM 0xA
        cpu_wr(16'h5043, 8'h08);
        cpu_wr(16'h5045, 8'hFF);
        cpu_wr(16'h5046, 8'h02);
        rom_fill(4'hA);
        run_tick(lat, a0, a1, a2, nvld, novr, bmid, bend);
        check("v0_t1_addr", 32'(a0), 32'h41);
        check("v0_t1_out", 32'(sample_out), 150);
        check("v0_t1_v1addr", 32'(a1), 0);
        run_tick(lat, a0, a1, a2, nvld, novr, bmid, bend);
        check("v0_t2_addr", 32'(a0), 32'h42);
        check("v0_t2_out", 32'(sample_out), 150);
        run_tick(lat, a0, a1, a2, nvld, novr, bmid, bend);
        check("v0_t3_addr", 32'(a0), 32'h43);
        check("v0_t3_out", 32'(sample_out), 150);
        check("v0_t3_latency", 32'(lat), 10);

        // All voices full volume, ROM 0xF: 3*225 = 675; 9-bit instance clamps
        cpu_wr(16'h504D, 8'h0F);
        cpu_wr(16'h5055, 8'h0F);
        rom_fill(4'hF);
        run_tick(lat, a0, a1, a2, nvld, novr, bmid, bend);
        check("full_out", 32'(sample_out), 675);
        check("full_sat9", 32'(sample_out_s), 511);
        check("full_v0addr", 32'(a0), 32'h44);

        // Distinct volumes 1/2/3, voice 1 wave 5 freq 0x10000, ROM word = wave+1
        cpu_wr(16'h5045, 8'h01);
        cpu_wr(16'h504D, 8'h02);
        cpu_wr(16'h5055, 8'h03);
        cpu_wr(16'h504E, 8'h05);
        cpu_wr(16'h504C, 8'h01);
        rom_by_wave();
        run_tick(lat, a0, a1, a2, nvld, novr, bmid, bend);
        check("mix_v0addr", 32'(a0), 32'h45);
        check("mix_v1addr", 32'(a1), 32'hA2);
        check("mix_v2addr", 32'(a2), 32'h00);
        check("mix_out", 32'(sample_out), 18);
        check("mix_out9", 32'(sample_out_s), 18);

        // Writes outside decoded registers are ignored
        cpu_wr(16'h505D, 8'h0F);
        cpu_wr(16'h5047, 8'h0F);
        cpu_wr(16'h503D, 8'h0F);
        run_tick(lat, a0, a1, a2, nvld, novr, bmid, bend);
        check("ign_out", 32'(sample_out), 18);
        check("ign_v0addr", 32'(a0), 32'h46);
        check("ign_v1addr", 32'(a1), 32'hA4);

        // Reset mid-sequence: no valid, everything cleared
        sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_out", 32'(sample_out), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_rom_addr", 32'(rom_addr), 0);
        nvld = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (sample_valid) nvld++;
        end
        check("midrst_nvalid", 32'(nvld), 0);

        // Voice registers were cleared: full-scale ROM still mixes to 0
        rom_fill(4'hF);
        run_tick(lat, a0, a1, a2, nvld, novr, bmid, bend);
        check("postrst_out", 32'(sample_out), 0);
        check("postrst_addr", 32'(a0), 0);

        // Accumulator wrap: freq 0xFFFF8 then 0x00008
        cpu_wr(16'h5040, 8'h08);
        cpu_wr(16'h5041, 8'h0F);
        cpu_wr(16'h5042, 8'h0F);
        cpu_wr(16'h5043, 8'h0F);
        cpu_wr(16'h5044, 8'h0F);
        cpu_wr(16'h5045, 8'h0F);
        cpu_wr(16'h5046, 8'h03);
        run_tick(lat, a0, a1, a2, nvld, novr, bmid, bend);
        check("wrap_pre_addr", 32'(a0), 32'h7F);
        check("wrap_pre_out", 32'(sample_out), 225);
        cpu_wr(16'h5041, 8'h00);
        cpu_wr(16'h5042, 8'h00);
        cpu_wr(16'h5043, 8'h00);
        cpu_wr(16'h5044, 8'h00);
        run_tick(lat, a0, a1, a2, nvld, novr, bmid, bend);
        check("wrap_addr", 32'(a0), 32'h60);

        // Tick 4 cycles into a sequence overruns; tick 11 cycles after is accepted
        lat = -1; nvld = 0; novr = 0;
        sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk);
            #1;
            if (sample_valid) begin
                nvld++;
                if (lat < 0) lat = c;
            end
            if (overrun) novr++;
            if (c == 3 || c == 10) sample_tick = 1'b1;
            if (c == 4 || c == 11) sample_tick = 1'b0;
        end
        check("ovr_count", 32'(novr), 1);
        check("ovr_nvalid", 32'(nvld), 2);
        check("ovr_latency", 32'(lat), 10);
        check("ovr_out", 32'(sample_out), 225);
        check("ovr_busy_end", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
